// File: rtl/refill_return_buffer.sv
// rtl/refill_return_buffer.sv - refill beat collector and 128-bit line return buffer
//
// Collects memory return beats after a cache miss, assembles one line on m_data,
// and owns the memory read-request handshake and the beat counter.
//
// Optional feature macro: CRITICAL_WORD_FIRST_EN
//   defined   : request address keeps the word offset, beats arrive in wrap
//               order starting at refill_addr[3:2]
//   undefined : request address is line aligned, beats arrive in order 0..3
//
// Ports:
//   clk, rst                   clock (rising edge), async active-high reset
//   refill_req_i/refill_addr_i miss FSM refill request, sampled in IDLE only
//   mem_rd_req_o/mem_rd_addr_o read request to memory, held until grant
//   mem_rd_gnt_i               memory accepts the request this cycle
//   mem_ret_valid_i/_data_i/_last_i  return beat stream
//   m_data_o                   assembled line, word i at [32i+31:32i]
//   word_valid_o               per-word "written in current refill" flags
//   refill_busy_o              high from request acceptance until DONE exits
//   refill_done_o              one-cycle completion pulse
//   proto_err_o                sticky protocol error (early or missing last)

module refill_return_buffer #(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         refill_req_i,
    input  logic [ADDR_W-1:0]            refill_addr_i,
    output logic                         mem_rd_req_o,
    output logic [ADDR_W-1:0]            mem_rd_addr_o,
    input  logic                         mem_rd_gnt_i,
    input  logic                         mem_ret_valid_i,
    input  logic [WORD_W-1:0]            mem_ret_data_i,
    input  logic                         mem_ret_last_i,
    output logic [LINE_WORDS*WORD_W-1:0] m_data_o,
    output logic [LINE_WORDS-1:0]        word_valid_o,
    output logic                         refill_busy_o,
    output logic                         refill_done_o,
    output logic                         proto_err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RECV = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [ADDR_W-1:0]              addr_q, addr_d;
    logic [1:0]                     cnt_q, cnt_d;     // word slot for next beat
    logic [1:0]                     beats_q, beats_d; // beats accepted so far
    logic [LINE_WORDS*WORD_W-1:0]   data_q, data_d;
    logic [LINE_WORDS-1:0]          valid_q, valid_d;
    logic                           err_q, err_d;

    logic [ADDR_W-1:0]              req_addr;
    logic [1:0]                     start_word;
    logic                           unused_addr_bits;

`ifdef CRITICAL_WORD_FIRST_EN
    assign req_addr   = {refill_addr_i[ADDR_W-1:2], 2'b00};
    assign start_word = refill_addr_i[3:2];
`else
    assign req_addr   = {refill_addr_i[ADDR_W-1:4], 4'b0000};
    assign start_word = 2'd0;
`endif
    // Low address bits are dropped from the request in one or both builds.
    assign unused_addr_bits = &{1'b0, refill_addr_i[3:0]};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        beats_d = beats_q;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (refill_req_i) begin
                    addr_d  = req_addr;
                    cnt_d   = start_word;
                    beats_d = 2'd0;
                    valid_d = '0;
                    err_d   = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // Return beats before the grant has been seen are not ours.
                if (mem_rd_gnt_i) begin
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (mem_ret_valid_i) begin
                    for (int i = 0; i < LINE_WORDS; i++) begin
                        if (cnt_q == i[1:0]) begin
                            data_d[i*WORD_W +: WORD_W] = mem_ret_data_i;
                            valid_d[i]                 = 1'b1;
                        end
                    end
                    cnt_d   = cnt_q + 2'd1;
                    beats_d = beats_q + 2'd1;
                    if (beats_q == 2'd3) begin
                        // Fourth beat always completes; a missing last is flagged.
                        state_d = S_DONE;
                        if (!mem_ret_last_i) begin
                            err_d = 1'b1;
                        end
                    end else if (mem_ret_last_i) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                // A request coinciding with the done pulse is not sampled here.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= 2'd0;
            beats_q <= 2'd0;
            data_q  <= '0;
            valid_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            beats_q <= beats_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign mem_rd_req_o  = (state_q == S_REQ);
    assign mem_rd_addr_o = addr_q;
    assign m_data_o      = data_q;
    assign word_valid_o  = valid_q;
    assign refill_busy_o = (state_q != S_IDLE);
    assign refill_done_o = (state_q == S_DONE);
    assign proto_err_o   = err_q;

endmodule

// File: tb/tb_refill_return_buffer.sv
// tb/tb_refill_return_buffer.sv - directed scoreboard bench for refill_return_buffer
module tb_refill_return_buffer;

`ifdef CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         refill_req;
    logic [31:0]  refill_addr;
    logic         mem_rd_req;
    logic [31:0]  mem_rd_addr;
    logic         mem_rd_gnt;
    logic         mem_ret_valid;
    logic [31:0]  mem_ret_data;
    logic         mem_ret_last;
    logic [127:0] m_data;
    logic [3:0]   word_valid;
    logic         refill_busy;
    logic         refill_done;
    logic         proto_err;

    refill_return_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .refill_req_i    (refill_req),
        .refill_addr_i   (refill_addr),
        .mem_rd_req_o    (mem_rd_req),
        .mem_rd_addr_o   (mem_rd_addr),
        .mem_rd_gnt_i    (mem_rd_gnt),
        .mem_ret_valid_i (mem_ret_valid),
        .mem_ret_data_i  (mem_ret_data),
        .mem_ret_last_i  (mem_ret_last),
        .m_data_o        (m_data),
        .word_valid_o    (word_valid),
        .refill_busy_o   (refill_busy),
        .refill_done_o   (refill_done),
        .proto_err_o     (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  idx;
        logic [31:0] data;
    } beat_t;

    beat_t        sb[$];
    int           tests = 0;
    int           fails = 0;
    logic [127:0] exp_line;
    logic [3:0]   exp_valid;
    logic [1:0]   exp_idx;
    logic [31:0]  exp_addr;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " mem_rd_req"}, 128'(mem_rd_req), 128'(0));
        check({tag, " mem_rd_addr"}, 128'(mem_rd_addr), 128'(0));
        check({tag, " m_data"}, m_data, 128'(0));
        check({tag, " word_valid"}, 128'(word_valid), 128'(0));
        check({tag, " busy"}, 128'(refill_busy), 128'(0));
        check({tag, " done"}, 128'(refill_done), 128'(0));
        check({tag, " proto_err"}, 128'(proto_err), 128'(0));
    endtask

    task automatic start_refill(input logic [31:0] addr);
        refill_req  = 1'b1;
        refill_addr = addr;
        tick();
        refill_req  = 1'b0;
        exp_addr    = CWF ? {addr[31:2], 2'b00} : {addr[31:4], 4'b0000};
        exp_idx     = CWF ? addr[3:2] : 2'd0;
        exp_valid   = 4'b0000;
        check("accept busy", 128'(refill_busy), 128'(1));
        check("accept mem_rd_req", 128'(mem_rd_req), 128'(1));
        check("accept mem_rd_addr", 128'(mem_rd_addr), 128'(exp_addr));
        check("accept proto_err clr", 128'(proto_err), 128'(0));
        check("accept word_valid clr", 128'(word_valid), 128'(0));
    endtask

    task automatic grant_after(input int n);
        repeat (n) begin
            check("wait mem_rd_req", 128'(mem_rd_req), 128'(1));
            check("wait mem_rd_addr", 128'(mem_rd_addr), 128'(exp_addr));
            mem_ret_valid = 1'b1;  // stray beat in REQ must be ignored
            mem_ret_data  = 32'hBAD0_0000;
            tick();
            mem_ret_valid = 1'b0;
        end
        mem_rd_gnt = 1'b1;
        tick();
        mem_rd_gnt = 1'b0;
        check("post-grant mem_rd_req", 128'(mem_rd_req), 128'(0));
        check("post-grant word_valid", 128'(word_valid), 128'(0));
    endtask

    task automatic beat(input logic [31:0] data, input logic last);
        beat_t b;
        mem_ret_valid = 1'b1;
        mem_ret_data  = data;
        mem_ret_last  = last;
        sb.push_back('{idx: exp_idx, data: data});
        exp_idx = exp_idx + 2'd1;
        tick();
        mem_ret_valid = 1'b0;
        mem_ret_last  = 1'b0;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL scoreboard: observed empty expected entry");
        end else begin
            b = sb.pop_front();
            exp_line[b.idx*32 +: 32] = b.data;
            exp_valid[b.idx] = 1'b1;
            check("beat m_data", m_data, exp_line);
            check("beat word_valid", 128'(word_valid), 128'(exp_valid));
        end
    endtask

    task automatic stall(input int n);
        repeat (n) begin
            tick();
            check("stall word_valid", 128'(word_valid), 128'(exp_valid));
            check("stall busy", 128'(refill_busy), 128'(1));
        end
    endtask

    task automatic expect_done(input logic err, input logic req_in_done, input logic [31:0] addr);
        check("done pulse", 128'(refill_done), 128'(1));
        check("done busy", 128'(refill_busy), 128'(1));
        check("done proto_err", 128'(proto_err), 128'(err));
        if (req_in_done) begin
            refill_req  = 1'b1;
            refill_addr = addr;
        end
        tick();
        check("after done pulse", 128'(refill_done), 128'(0));
        check("after done busy", 128'(refill_busy), 128'(0));
        check("after done mem_rd_req", 128'(mem_rd_req), 128'(0));
        check("after done word_valid", 128'(word_valid), 128'(exp_valid));
    endtask

    initial begin
        rst = 1'b1;
        refill_req = 1'b0; refill_addr = '0; mem_rd_gnt = 1'b0;
        mem_ret_valid = 1'b0; mem_ret_data = '0; mem_ret_last = 1'b0;
        exp_line = '0; exp_valid = '0; exp_idx = '0; exp_addr = '0;
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Basic aligned-latency refill
        start_refill(32'h1000_0024);
        grant_after(0);
        beat(32'hA0, 1'b0); beat(32'hA1, 1'b0); beat(32'hA2, 1'b0); beat(32'hA3, 1'b1);
        if (!CWF) begin
            check("basic addr", 128'(mem_rd_addr), 128'(32'h1000_0020));
            check("basic line", m_data, 128'h000000A3_000000A2_000000A1_000000A0);
        end
        check("basic word_valid", 128'(word_valid), 128'(4'hF));
        expect_done(1'b0, 1'b0, 32'h0);

        // Grant and beat stalls; request during done pulse is not taken
        start_refill(32'h1000_0000);
        grant_after(3);
        beat(32'h50, 1'b0); stall(1); beat(32'h51, 1'b0); stall(1);
        beat(32'h52, 1'b0); stall(1); beat(32'h53, 1'b1);
        expect_done(1'b0, 1'b1, 32'h1000_0040);

        // Early last on second beat; request held from done cycle accepted now
        start_refill(32'h1000_0040);
        grant_after(0);
        beat(32'hC0, 1'b0); beat(32'hC1, 1'b1);
        check("early word_valid", 128'(word_valid), 128'(4'b0011));
        check("early stale line", m_data, exp_line);
        expect_done(1'b1, 1'b0, 32'h0);

        // Request while busy, then stray beats in IDLE
        start_refill(32'h1000_0080);
        grant_after(0);
        beat(32'hD0, 1'b0);
        refill_req = 1'b1; refill_addr = 32'h2000_0000;
        beat(32'hD1, 1'b0);
        check("busy no new req", 128'(mem_rd_req), 128'(0));
        check("busy addr held", 128'(mem_rd_addr), 128'(exp_addr));
        refill_req = 1'b0;
        beat(32'hD2, 1'b0); beat(32'hD3, 1'b1);
        expect_done(1'b0, 1'b0, 32'h0);
        mem_ret_valid = 1'b1; mem_ret_data = 32'hDEAD_BEEF; mem_ret_last = 1'b1;
        tick(); tick();
        mem_ret_valid = 1'b0; mem_ret_last = 1'b0;
        check("stray m_data", m_data, exp_line);
        check("stray word_valid", 128'(word_valid), 128'(4'hF));
        check("stray proto_err", 128'(proto_err), 128'(0));
        check("stray done", 128'(refill_done), 128'(0));

        // Reset mid-refill, then a 4th beat with no last
        start_refill(32'h1000_00C0);
        grant_after(0);
        beat(32'hE0, 1'b0); beat(32'hE1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_reset_vals("mid reset");
        exp_line = '0;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        tick();
        start_refill(32'h1000_0100);
        grant_after(1);
        beat(32'hF0, 1'b0); beat(32'hF1, 1'b0); beat(32'hF2, 1'b0); beat(32'hF3, 1'b0);
        expect_done(1'b1, 1'b0, 32'h0);

        // Non-aligned word offset (wrap order when critical-word-first is built in)
        start_refill(32'h1000_0028);
        grant_after(0);
        beat(32'hB0, 1'b0);
        check("first beat word_valid", 128'(word_valid), 128'(CWF ? 4'b0100 : 4'b0001));
        beat(32'hB1, 1'b0); beat(32'hB2, 1'b0); beat(32'hB3, 1'b1);
        if (CWF) begin
            check("cwf addr", 128'(mem_rd_addr), 128'(32'h1000_0028));
            check("cwf line", m_data, 128'h000000B1_000000B0_000000B3_000000B2);
        end else begin
            check("offset addr", 128'(mem_rd_addr), 128'(32'h1000_0020));
            check("offset line", m_data, 128'h000000B3_000000B2_000000B1_000000B0);
        end
        expect_done(1'b0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
